cache_controller: RTL and testbench
===================================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 64, meaning max cycles to wait for mem_ack before aborting.
REQ-002 Parameter: CNT_WIDTH, default 16, meaning width of hit/miss statistics counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cpu_req_valid  input  1  CPU request present.
REQ-006 cpu_req_type  input  1  0 = read, 1 = write.
REQ-007 cpu_req_ready  output  1  controller can accept a request.
REQ-008 cpu_done  output  1  one-cycle completion pulse.
REQ-009 cpu_error  output  1  qualifies cpu_done; 1 = memory timeout abort.
REQ-010 hit  input  1  hit from cache_memory, combinational on the current request.
REQ-011 dirty_bit  input  1  dirty flag of the victim line, from cache_memory.
REQ-012 req_type  output  1  registered request type driven to cache_memory.
REQ-013 read_en_cache / write_en_cache  output  1 each  cache lookup enables.
REQ-014 read_en_mem / write_en_mem  output  1 each  refill-into-cache / victim-out enables.
REQ-015 mem_rd_req / mem_wr_req  output  1 each  main-memory block read/write request.
REQ-016 mem_ack  input  1  main memory done; refill data valid on data_in_mem in the same cycle.
REQ-017 hit_count / miss_count  output  CNT_WIDTH each  statistics.

Function
REQ-018 FSM states SHALL be IDLE, COMPARE, WRITE_BACK, ALLOCATE, RESPOND.
REQ-019 IDLE: cpu_req_ready=1; on cpu_req_valid, latch cpu_req_type into req_type and go to COMPARE; otherwise stay in IDLE.
REQ-020 COMPARE (one cycle): read_en_cache=~req_type, write_en_cache=req_type; hit and dirty_bit are sampled at the end of the cycle.
REQ-021 COMPARE with hit=1 SHALL go to RESPOND; with hit=0 and dirty_bit=1 SHALL go to WRITE_BACK; with hit=0 and dirty_bit=0 SHALL go to ALLOCATE.
REQ-022 A first-pass COMPARE SHALL increment hit_count on hit or miss_count on miss; the post-refill retry COMPARE SHALL NOT count.
REQ-023 Counters SHALL saturate at all-ones and not wrap.
REQ-024 WRITE_BACK: mem_wr_req=1 and write_en_mem=1 are held until mem_ack=1, then go to ALLOCATE.
REQ-025 ALLOCATE: mem_rd_req is held at 1; in the mem_ack cycle read_en_mem=1 for exactly that cycle (combinational from mem_ack), then go to COMPARE as a retry.
REQ-026 RESPOND: cpu_done=1 for one cycle, cpu_error per REQ-028, then go to IDLE; cpu_req_ready=0 in every non-IDLE state.
REQ-027 A wait counter SHALL clear on entry to WRITE_BACK/ALLOCATE and increment each cycle without mem_ack.
REQ-028 A count reaching MEM_TIMEOUT SHALL drop the memory request, set the error flag and go to RESPOND (cpu_done=1, cpu_error=1); the next accepted request SHALL clear the error flag.
REQ-029 mem_ack in the same cycle the timeout is reached SHALL win: treated as a normal ack, no error.
REQ-030 mem_ack outside WRITE_BACK/ALLOCATE SHALL be ignored.
REQ-031 At most one of mem_rd_req / mem_wr_req, and at most one cache enable, SHALL be high in any cycle.
REQ-032 Latency: hit = 3 cycles from acceptance to cpu_done; clean miss = 3 + ack wait + 2.

Reset
REQ-033 rst=1 SHALL force IDLE and set all enables, memory requests, cpu_done, cpu_error, req_type, wait counter and both stats counters to 0, with cpu_req_ready=1 on the first cycle after rst deasserts.
REQ-034 rst mid-transaction SHALL abort with no cpu_done; an outstanding mem_ack after reset SHALL be ignored.

Verification
REQ-035 Read hit: hit=1 in COMPARE -> read_en_cache for 1 cycle, cpu_done cycle 3, hit_count=1, no mem requests.
REQ-036 Clean read miss: hit=0, dirty=0, mem_ack after 5 cycles -> mem_rd_req 6 cycles, read_en_mem 1 cycle, retry COMPARE hit, cpu_done, miss_count=1, hit_count=0.
REQ-037 Dirty write miss: hit=0, dirty=1 -> WRITE_BACK (write_en_mem until ack), then ALLOCATE, then retry write_en_cache, cpu_done with cpu_error=0.
REQ-038 Timeout: MEM_TIMEOUT=8, mem_ack never -> mem_rd_req drops after 8 cycles, cpu_done=1 with cpu_error=1, back to IDLE.
REQ-039 Reset during ALLOCATE, then a late mem_ack -> IDLE, no read_en_mem, no cpu_done, counters 0.
REQ-040 Saturation: CNT_WIDTH=2, 5 read hits -> hit_count=3.

Source files
------------

// File: rtl/cache_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : cache_controller_if
//  Description : CPU handshake, cache_memory lookup/refill and main-memory
//                request signals shared by the cache controller and its
//                environment. The controller uses the master view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cache_controller_if;
  // CPU side
  logic cpu_req_valid;
  logic cpu_req_type;
  logic cpu_req_ready;
  logic cpu_done;
  logic cpu_error;
  // cache_memory side
  logic hit;
  logic dirty_bit;
  logic req_type;
  logic read_en_cache;
  logic write_en_cache;
  logic read_en_mem;
  logic write_en_mem;
  // main-memory side
  logic mem_rd_req;
  logic mem_wr_req;
  logic mem_ack;

  modport master (
    input  cpu_req_valid,
    input  cpu_req_type,
    input  hit,
    input  dirty_bit,
    input  mem_ack,
    output cpu_req_ready,
    output cpu_done,
    output cpu_error,
    output req_type,
    output read_en_cache,
    output write_en_cache,
    output read_en_mem,
    output write_en_mem,
    output mem_rd_req,
    output mem_wr_req
  );

  modport slave (
    output cpu_req_valid,
    output cpu_req_type,
    output hit,
    output dirty_bit,
    output mem_ack,
    input  cpu_req_ready,
    input  cpu_done,
    input  cpu_error,
    input  req_type,
    input  read_en_cache,
    input  write_en_cache,
    input  read_en_mem,
    input  write_en_mem,
    input  mem_rd_req,
    input  mem_wr_req
  );
endinterface
`default_nettype wire

// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : cache_controller
//  Description : Write-back cache control FSM. Looks up the cache, writes back
//                dirty victims, refills from main memory with a bounded wait,
//                and keeps saturating hit/miss statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_controller #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_controller_if.master   bus,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  // Value of the wait counter in the last cycle before the timeout is reached.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_COMPARE    = 3'd1,
    ST_WRITE_BACK = 3'd2,
    ST_ALLOCATE   = 3'd3,
    ST_RESPOND    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  req_type_q, req_type_d;
  logic                  error_q, error_d;
  logic                  retry_q, retry_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  rd_cache_q, rd_cache_d;
  logic                  wr_cache_q, wr_cache_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  wait_expired;

  // Timeout only counts when no ack arrives in the same cycle (ack wins).
  assign wait_expired = !bus.mem_ack && (wait_q == WAIT_LAST);

  // Next-state, statistics, wait-counter and registered-output decode.
  always_comb begin
    state_d    = state_q;
    req_type_d = req_type_q;
    error_d    = error_q;
    retry_d    = retry_q;
    wait_d     = wait_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req_valid) begin
          state_d    = ST_COMPARE;
          req_type_d = bus.cpu_req_type;
          error_d    = 1'b0;
          retry_d    = 1'b0;
        end
      end
      ST_COMPARE: begin
        // Only the first lookup of a request contributes to statistics.
        if (!retry_q) begin
          if (bus.hit) begin
            if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
          end else begin
            if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
          end
        end
        if (bus.hit) begin
          state_d = ST_RESPOND;
        end else begin
          wait_d  = '0;
          state_d = bus.dirty_bit ? ST_WRITE_BACK : ST_ALLOCATE;
        end
      end
      ST_WRITE_BACK: begin
        if (bus.mem_ack) begin
          wait_d  = '0;
          state_d = ST_ALLOCATE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_expired) begin
            error_d = 1'b1;
            state_d = ST_RESPOND;
          end
        end
      end
      ST_ALLOCATE: begin
        if (bus.mem_ack) begin
          retry_d = 1'b1;
          state_d = ST_COMPARE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_expired) begin
            error_d = 1'b1;
            state_d = ST_RESPOND;
          end
        end
      end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they are glitch-free flops.
    ready_d    = (state_d == ST_IDLE);
    done_d     = (state_d == ST_RESPOND);
    rd_cache_d = (state_d == ST_COMPARE) && !req_type_d;
    wr_cache_d = (state_d == ST_COMPARE) &&  req_type_d;
    mem_rd_d   = (state_d == ST_ALLOCATE);
    mem_wr_d   = (state_d == ST_WRITE_BACK);
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_type_q <= 1'b0;
      error_q    <= 1'b0;
      retry_q    <= 1'b0;
      wait_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      rd_cache_q <= 1'b0;
      wr_cache_q <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_type_q <= req_type_d;
      error_q    <= error_d;
      retry_q    <= retry_d;
      wait_q     <= wait_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      rd_cache_q <= rd_cache_d;
      wr_cache_q <= wr_cache_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  assign bus.cpu_req_ready  = ready_q;
  assign bus.cpu_done       = done_q;
  assign bus.cpu_error      = error_q;
  assign bus.req_type       = req_type_q;
  assign bus.read_en_cache  = rd_cache_q;
  assign bus.write_en_cache = wr_cache_q;
  // Refill strobe must coincide with the data on the memory bus.
  assign bus.read_en_mem    = (state_q == ST_ALLOCATE) && bus.mem_ack;
  assign bus.write_en_mem   = mem_wr_q;
  assign bus.mem_rd_req     = mem_rd_q;
  assign bus.mem_wr_req     = mem_wr_q;
  assign hit_count          = hit_cnt_q;
  assign miss_count         = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_controller
//  Description : Directed self-checking bench for cache_controller
//                (MEM_TIMEOUT=8, CNT_WIDTH=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_controller;

  logic       clk;
  logic       rst;
  logic [1:0] hit_count;
  logic [1:0] miss_count;
  int         n_checks;
  int         n_pass;

  cache_controller_if bus ();

  cache_controller #(
    .MEM_TIMEOUT(8),
    .CNT_WIDTH  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_type  = 1'b0;
    bus.hit           = 1'b0;
    bus.dirty_bit     = 1'b0;
    bus.mem_ack       = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Present a request in the current cycle; returns at the COMPARE cycle.
  task automatic accept(input logic wr);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_type  = wr;
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_type  = 1'b0;
  endtask

  // Stimulus only: one complete read hit, ending back in IDLE.
  task automatic run_read_hit();
    accept(1'b0);
    bus.hit = 1'b1;
    @(negedge clk);
    bus.hit = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.cpu_req_ready !== 1'b1) $display("FAIL reset_ready: got %b exp 1", bus.cpu_req_ready); else n_pass++;
    n_checks++; if ({bus.cpu_done, bus.cpu_error, bus.req_type} !== 3'b000) $display("FAIL reset_done_err_type: got %b exp 000", {bus.cpu_done, bus.cpu_error, bus.req_type}); else n_pass++;
    n_checks++; if ({bus.read_en_cache, bus.write_en_cache, bus.read_en_mem, bus.write_en_mem, bus.mem_rd_req, bus.mem_wr_req} !== 6'b0)
      $display("FAIL reset_enables: got %b exp 000000", {bus.read_en_cache, bus.write_en_cache, bus.read_en_mem, bus.write_en_mem, bus.mem_rd_req, bus.mem_wr_req}); else n_pass++;
    n_checks++; if ({hit_count, miss_count} !== 4'b0) $display("FAIL reset_counts: got %h/%h exp 0/0", hit_count, miss_count); else n_pass++;
  endtask

  task automatic test_read_hit();
    do_reset();
    accept(1'b0);
    n_checks++; if ({bus.read_en_cache, bus.write_en_cache, bus.cpu_req_ready} !== 3'b100) $display("FAIL rh_compare: got rd/wr/rdy %b exp 100", {bus.read_en_cache, bus.write_en_cache, bus.cpu_req_ready}); else n_pass++;
    bus.hit = 1'b1;
    @(negedge clk);
    bus.hit = 1'b0;
    n_checks++; if ({bus.cpu_done, bus.cpu_error, bus.read_en_cache} !== 3'b100) $display("FAIL rh_respond: got done/err/rd %b exp 100", {bus.cpu_done, bus.cpu_error, bus.read_en_cache}); else n_pass++;
    n_checks++; if ({hit_count, miss_count} !== 4'b0100) $display("FAIL rh_counts: got %0d/%0d exp 1/0", hit_count, miss_count); else n_pass++;
    n_checks++; if ({bus.mem_rd_req, bus.mem_wr_req} !== 2'b00) $display("FAIL rh_no_mem: got %b exp 00", {bus.mem_rd_req, bus.mem_wr_req}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({bus.cpu_done, bus.cpu_req_ready} !== 2'b01) $display("FAIL rh_idle: got done/rdy %b exp 01", {bus.cpu_done, bus.cpu_req_ready}); else n_pass++;
  endtask

  task automatic test_clean_miss();
    int rd_cycles;
    int ren_cycles;
    rd_cycles  = 0;
    ren_cycles = 0;
    do_reset();
    accept(1'b0);
    bus.hit = 1'b0;
    bus.dirty_bit = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.mem_rd_req === 1'b1) rd_cycles++;
      bus.mem_ack = (i == 5);
      #1;
      if (bus.read_en_mem === 1'b1) ren_cycles++;
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    if (bus.read_en_mem === 1'b1) ren_cycles++;
    n_checks++; if (rd_cycles !== 6) $display("FAIL cm_rd_req_len: got %0d exp 6", rd_cycles); else n_pass++;
    n_checks++; if (ren_cycles !== 1) $display("FAIL cm_read_en_mem_len: got %0d exp 1", ren_cycles); else n_pass++;
    n_checks++; if ({bus.read_en_cache, bus.mem_rd_req, bus.cpu_done} !== 3'b100) $display("FAIL cm_retry: got rd/memrd/done %b exp 100", {bus.read_en_cache, bus.mem_rd_req, bus.cpu_done}); else n_pass++;
    bus.hit = 1'b1;
    @(negedge clk);
    bus.hit = 1'b0;
    n_checks++; if ({bus.cpu_done, bus.cpu_error} !== 2'b10) $display("FAIL cm_done: got done/err %b exp 10", {bus.cpu_done, bus.cpu_error}); else n_pass++;
    n_checks++; if ({hit_count, miss_count} !== 4'b0001) $display("FAIL cm_counts: got %0d/%0d exp 0/1", hit_count, miss_count); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_dirty_write_miss();
    int wr_cycles;
    wr_cycles = 0;
    do_reset();
    accept(1'b1);
    n_checks++; if ({bus.write_en_cache, bus.read_en_cache, bus.req_type} !== 3'b101) $display("FAIL dw_compare: got wr/rd/type %b exp 101", {bus.write_en_cache, bus.read_en_cache, bus.req_type}); else n_pass++;
    bus.hit = 1'b0;
    bus.dirty_bit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.dirty_bit = 1'b0;
      if ({bus.mem_wr_req, bus.write_en_mem, bus.mem_rd_req} === 3'b110) wr_cycles++;
      bus.mem_ack = (i == 2);
    end
    n_checks++; if (wr_cycles !== 3) $display("FAIL dw_writeback_len: got %0d exp 3", wr_cycles); else n_pass++;
    @(negedge clk);
    n_checks++; if ({bus.mem_rd_req, bus.mem_wr_req, bus.write_en_mem} !== 3'b100) $display("FAIL dw_allocate: got rd/wr/wen %b exp 100", {bus.mem_rd_req, bus.mem_wr_req, bus.write_en_mem}); else n_pass++;
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    n_checks++; if ({bus.write_en_cache, bus.read_en_cache, bus.mem_rd_req} !== 3'b100) $display("FAIL dw_retry: got wr/rd/memrd %b exp 100", {bus.write_en_cache, bus.read_en_cache, bus.mem_rd_req}); else n_pass++;
    bus.hit = 1'b1;
    @(negedge clk);
    bus.hit = 1'b0;
    n_checks++; if ({bus.cpu_done, bus.cpu_error, miss_count, hit_count} !== 6'b100100) $display("FAIL dw_done: got done/err %b%b miss/hit %0d/%0d exp 10 1/0", bus.cpu_done, bus.cpu_error, miss_count, hit_count); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int  rd_cycles;
    bit  seen;
    logic err;
    rd_cycles = 0;
    seen = 1'b0;
    err = 1'b0;
    do_reset();
    accept(1'b0);
    bus.hit = 1'b0;
    bus.dirty_bit = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_rd_req === 1'b1) rd_cycles++;
      if (bus.cpu_done === 1'b1) begin
        seen = 1'b1;
        err  = bus.cpu_error;
      end
    end
    n_checks++; if (rd_cycles !== 8) $display("FAIL to_rd_req_len: got %0d exp 8", rd_cycles); else n_pass++;
    n_checks++; if ({seen, err} !== 2'b11) $display("FAIL to_done_error: got seen/err %b%b exp 11", seen, err); else n_pass++;
    @(negedge clk);
    n_checks++; if ({bus.cpu_req_ready, bus.cpu_done} !== 2'b10) $display("FAIL to_idle: got rdy/done %b exp 10", {bus.cpu_req_ready, bus.cpu_done}); else n_pass++;
    // A fresh request clears the error flag.
    accept(1'b0);
    bus.hit = 1'b1;
    @(negedge clk);
    bus.hit = 1'b0;
    n_checks++; if ({bus.cpu_done, bus.cpu_error} !== 2'b10) $display("FAIL to_next_clears_err: got done/err %b exp 10", {bus.cpu_done, bus.cpu_error}); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_ack_at_timeout();
    int rd_cycles;
    rd_cycles = 0;
    do_reset();
    accept(1'b0);
    bus.hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.mem_rd_req === 1'b1) rd_cycles++;
      bus.mem_ack = (i == 7);
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    n_checks++; if (rd_cycles !== 8) $display("FAIL at_rd_req_len: got %0d exp 8", rd_cycles); else n_pass++;
    n_checks++; if ({bus.read_en_cache, bus.cpu_done} !== 2'b10) $display("FAIL at_retry: got rd/done %b exp 10", {bus.read_en_cache, bus.cpu_done}); else n_pass++;
    bus.hit = 1'b1;
    @(negedge clk);
    bus.hit = 1'b0;
    n_checks++; if ({bus.cpu_done, bus.cpu_error} !== 2'b10) $display("FAIL at_done_no_err: got done/err %b exp 10", {bus.cpu_done, bus.cpu_error}); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_allocate();
    int bad;
    bad = 0;
    do_reset();
    accept(1'b0);
    bus.hit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.read_en_mem !== 1'b0 || bus.cpu_done !== 1'b0 || bus.mem_rd_req !== 1'b0) bad++;
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
    n_checks++; if (bad !== 0) $display("FAIL rm_late_ack_ignored: got %0d bad cycles exp 0", bad); else n_pass++;
    n_checks++; if ({bus.cpu_req_ready, hit_count, miss_count} !== 5'b10000) $display("FAIL rm_idle_counts: got rdy %b hit/miss %0d/%0d exp 1 0/0", bus.cpu_req_ready, hit_count, miss_count); else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) run_read_hit();
    n_checks++; if (hit_count !== 2'd3) $display("FAIL sat_hit_count: got %0d exp 3", hit_count); else n_pass++;
    n_checks++; if (miss_count !== 2'd0) $display("FAIL sat_miss_count: got %0d exp 0", miss_count); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_type  = 1'b0;
    bus.hit           = 1'b0;
    bus.dirty_bit     = 1'b0;
    bus.mem_ack       = 1'b0;
    test_reset();
    test_read_hit();
    test_clean_miss();
    test_dirty_write_miss();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid_allocate();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
